// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared constants and state encoding for the MaxNet controller.
//   N        number of neurons (matches the datapath)
//   IDX_W    width of a neuron index, clog2(N)
//   MAX_ITER datapath passes allowed before a run times out
//   ITER_W   iteration counter width, able to hold MAX_ITER
package maxnet_pkg;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_ITER = 16;
  localparam int ITER_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/onehot_detect.sv
// onehot_detect: combinational classifier for the captured neuron flags.
//   flags      in  N      per-neuron nonzero flags
//   is_zero    out 1      no flag set
//   is_onehot  out 1      exactly one flag set
//   idx        out IDX_W  index of the lowest set flag (0 when none set)
module onehot_detect
  import maxnet_pkg::*;
(
  input  logic [N-1:0]     flags,
  output logic             is_zero,
  output logic             is_onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    is_zero   = (flags == '0);
    // Clearing the lowest set bit leaves nothing only for a single-bit value.
    is_onehot = !is_zero && ((flags & (flags - N'(1))) == '0);
    idx       = '0;
    // Scan downward so the last hit, the lowest set bit, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (flags[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM for the 4-neuron MaxNet datapath.
// Loads the initial activations, fires datapath passes and feeds results
// back until one neuron survives, all die out, or MAX_ITER passes elapse.
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   begin a run (sampled in IDLE only)
//   dp_done      in   datapath pass complete, nz_flags valid
//   nz_flags     in   N per-neuron nonzero flags
//   sel_src      out  neuron register source: 0 = memory X, 1 = feedback
//   reg_ld       out  neuron register load enable
//   dp_start     out  one-cycle datapath start pulse
//   busy         out  high outside IDLE
//   done         out  one-cycle end-of-run pulse
//   winner       out  IDX_W index of the surviving neuron
//   winner_valid out  winner is meaningful
//   timeout      out  run ended on the iteration limit
//   iter_cnt     out  ITER_W completed passes in current/last run
module maxnet_controller
  import maxnet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dp_done,
  input  logic [N-1:0]      nz_flags,
  output logic              sel_src,
  output logic              reg_ld,
  output logic              dp_start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  winner,
  output logic              winner_valid,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t           state;
  logic [N-1:0]     flag_q;
  logic             is_zero;
  logic             is_onehot;
  logic [IDX_W-1:0] low_idx;

  onehot_detect u_detect (
    .flags     (flag_q),
    .is_zero   (is_zero),
    .is_onehot (is_onehot),
    .idx       (low_idx)
  );

  // Moore strobes from the registered state; the feedback load in WAIT
  // is Mealy so the neuron registers capture results in the dp_done cycle.
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign dp_start = (state == RUN);
  assign reg_ld   = (state == INIT) || ((state == WAIT) && dp_done);
  assign sel_src  = (state == WAIT) && dp_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flag_q       <= '0;
      iter_cnt     <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= INIT;
        end
        INIT: begin
          iter_cnt     <= '0;
          winner       <= '0;
          winner_valid <= 1'b0;
          timeout      <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          state <= WAIT;
        end
        WAIT: begin
          if (dp_done) begin
            flag_q <= nz_flags;
            // Saturate so the counter can never pass the limit or wrap.
            if (iter_cnt < ITER_W'(MAX_ITER)) iter_cnt <= iter_cnt + ITER_W'(1);
            state  <= CHECK;
          end
        end
        CHECK: begin
          // A single survivor outranks the iteration limit.
          if (is_onehot) begin
            winner       <= low_idx;
            winner_valid <= 1'b1;
            state        <= DONE;
          end else if (is_zero) begin
            winner       <= '0;
            winner_valid <= 1'b0;
            state        <= DONE;
          end else if (iter_cnt == ITER_W'(MAX_ITER)) begin
            timeout      <= 1'b1;
            winner_valid <= 1'b0;
            state        <= DONE;
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: directed plus randomized checks of maxnet_controller
// against a pass-level reference model of a MaxNet run.
module tb_maxnet_controller;
  import maxnet_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              dp_done;
  logic [N-1:0]      nz_flags;
  logic              sel_src;
  logic              reg_ld;
  logic              dp_start;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  winner;
  logic              winner_valid;
  logic              timeout;
  logic [ITER_W-1:0] iter_cnt;

  int checks = 0;
  int errors = 0;
  int n_dpstart = 0;
  int n_regld = 0;

  typedef struct {
    int passes;
    int win;
    bit valid;
    bit tmo;
  } res_t;

  maxnet_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dp_done      (dp_done),
    .nz_flags     (nz_flags),
    .sel_src      (sel_src),
    .reg_ld       (reg_ld),
    .dp_start     (dp_start),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_valid (winner_valid),
    .timeout      (timeout),
    .iter_cnt     (iter_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the active edge.
  always @(posedge clk) begin
    if (dp_start) n_dpstart <= n_dpstart + 1;
    if (reg_ld)   n_regld   <= n_regld + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run outcome from the pass rules: stop on one survivor or none,
  // otherwise give up after MAX_ITER passes.
  function automatic res_t model(input logic [N-1:0] seq[$]);
    res_t r;
    r.passes = 0; r.win = 0; r.valid = 0; r.tmo = 0;
    for (int p = 0; p < seq.size(); p++) begin
      int pop;
      pop = $countones(seq[p]);
      r.passes = p + 1;
      if (pop == 1) begin
        for (int b = 0; b < N; b++) if (seq[p][b]) r.win = b;
        r.valid = 1;
        return r;
      end
      if (pop == 0) return r;
      if (r.passes == MAX_ITER) begin
        r.tmo = 1;
        return r;
      end
    end
    return r;
  endfunction

  // Drive one full run; dp_done arrives dly cycles after each dp_start.
  task automatic do_run(input logic [N-1:0] seq[$], input int dly, input bit hold_start,
                        input string nm);
    res_t r;
    int s0, l0;
    r  = model(seq);
    s0 = n_dpstart;
    l0 = n_regld;
    start = 1'b1;
    @(negedge clk);
    chk({nm, ".init_ld"},  32'(reg_ld), 1);
    chk({nm, ".init_src"}, 32'(sel_src), 0);
    chk({nm, ".init_busy"}, 32'(busy), 1);
    if (!hold_start) start = 1'b0;
    for (int p = 0; p < r.passes; p++) begin
      @(negedge clk);
      chk({nm, ".dp_start"}, 32'(dp_start), 1);
      @(negedge clk);
      for (int w = 1; w < dly; w++) begin
        chk({nm, ".wait_ld"}, 32'(reg_ld), 0);
        @(negedge clk);
      end
      dp_done  = 1'b1;
      nz_flags = seq[p];
      #1;
      chk({nm, ".fb_ld"},  32'(reg_ld), 1);
      chk({nm, ".fb_src"}, 32'(sel_src), 1);
      @(negedge clk);
      dp_done  = 1'b0;
      nz_flags = N'($urandom_range(0, 15));
      chk({nm, ".iter"},     32'(iter_cnt), p + 1);
      chk({nm, ".chk_strt"}, 32'(dp_start), 0);
      chk({nm, ".chk_done"}, 32'(done), 0);
    end
    @(negedge clk);
    chk({nm, ".done"},     32'(done), 1);
    chk({nm, ".no_start"}, 32'(dp_start), 0);
    chk({nm, ".winner"},   32'(winner), r.valid ? r.win : 0);
    chk({nm, ".wvalid"},   32'(winner_valid), 32'(r.valid));
    chk({nm, ".timeout"},  32'(timeout), 32'(r.tmo));
    chk({nm, ".iter_end"}, 32'(iter_cnt), r.passes);
    chk({nm, ".n_start"},  n_dpstart - s0, r.passes);
    chk({nm, ".n_ld"},     n_regld - l0, r.passes + 1);
    @(negedge clk);
    chk({nm, ".idle_busy"}, 32'(busy), 0);
    chk({nm, ".idle_done"}, 32'(done), 0);
    chk({nm, ".hold_iter"}, 32'(iter_cnt), r.passes);
    chk({nm, ".hold_wv"},   32'(winner_valid), 32'(r.valid));
  endtask

  initial begin
    logic [N-1:0] seq[$];
    rst = 1'b1; start = 1'b0; dp_done = 1'b0; nz_flags = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy",     32'(busy), 0);
    chk("rst.done",     32'(done), 0);
    chk("rst.reg_ld",   32'(reg_ld), 0);
    chk("rst.dp_start", 32'(dp_start), 0);
    chk("rst.winner",   32'(winner), 0);
    chk("rst.iter",     32'(iter_cnt), 0);
    chk("rst.wvalid",   32'(winner_valid), 0);
    chk("rst.timeout",  32'(timeout), 0);
    rst = 1'b0;
    @(negedge clk);

    seq = '{4'b1111, 4'b1100, 4'b1000};
    do_run(seq, 3, 1'b0, "win");

    seq = '{4'b0000};
    do_run(seq, 1, 1'b0, "zero");

    seq = {};
    for (int i = 0; i < MAX_ITER; i++) seq.push_back(4'b0011);
    do_run(seq, 1, 1'b0, "tmo");

    for (int k = 0; k < 8; k++) begin
      seq = {};
      for (int i = 0; i < MAX_ITER; i++) seq.push_back(N'($urandom_range(0, 15)));
      do_run(seq, $urandom_range(1, 4), 1'b0, $sformatf("rnd%0d", k));
    end

    // Reset lands in the second WAIT cycle, then a stray dp_done in IDLE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.busy",   32'(busy), 0);
    chk("mid.iter",   32'(iter_cnt), 0);
    chk("mid.winner", 32'(winner), 0);
    dp_done  = 1'b1;
    nz_flags = 4'b0100;
    #1;
    chk("mid.stray_ld", 32'(reg_ld), 0);
    @(negedge clk);
    dp_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid.done",   32'(done), 0);
      chk("mid.busy2",  32'(busy), 0);
      chk("mid.wvalid", 32'(winner_valid), 0);
      chk("mid.iter2",  32'(iter_cnt), 0);
      @(negedge clk);
    end

    // start held high for a whole run: exactly one IDLE cycle, then INIT.
    seq = '{4'b1111, 4'b1100, 4'b1000};
    do_run(seq, 2, 1'b1, "hold");
    @(negedge clk);
    chk("hold.reinit_ld",  32'(reg_ld), 1);
    chk("hold.reinit_src", 32'(sel_src), 0);
    start = 1'b0;
    @(negedge clk);
    chk("hold.rerun",   32'(dp_start), 1);
    chk("hold.clr_wv",  32'(winner_valid), 0);
    chk("hold.clr_it",  32'(iter_cnt), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("end.busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
